// File: rtl/led_seq_pkg.sv
// LED sequencer shared constants and pattern helpers.
// Patterns are built 16 bits wide and trimmed to LED_W by the caller.
package led_seq_pkg;

  localparam logic [1:0] MODE_WALK     = 2'd0;
  localparam logic [1:0] MODE_MIRROR   = 2'd1;
  localparam logic [1:0] MODE_COUNT    = 2'd2;
  localparam logic [1:0] MODE_PINGPONG = 2'd3;

  localparam int STEP_W = 5;
  localparam int MAX_W  = 16;

  function automatic logic [STEP_W-1:0] step_len(
    input logic [1:0] mode,
    input int         w
  );
    logic [STEP_W-1:0] r;
    case (mode)
      MODE_WALK:   r = STEP_W'(w + 5);
      MODE_MIRROR: r = STEP_W'(w + 7);
      MODE_COUNT:  r = STEP_W'(16);
      default:     r = STEP_W'(2 * w - 2);
    endcase
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] pattern(
    input logic [1:0]        mode,
    input logic [STEP_W-1:0] step,
    input int                w
  );
    logic [MAX_W-1:0] r;
    logic [MAX_W-1:0] ones;
    int s;
    s    = int'(step);
    ones = MAX_W'((32'd1 << w) - 32'd1);
    r    = '0;
    case (mode)
      MODE_WALK: begin
        if (s < w)
          r = MAX_W'(1) << (w - 1 - s);
        else if (((s - w) & 1) != 0)
          r = ones;
      end
      MODE_MIRROR: begin
        if (s < w)
          r = (MAX_W'(1) << (w - 1 - s))
            | (MAX_W'(1) << s);
        else if (((s - w) & 1) != 0)
          r = ones;
      end
      MODE_COUNT: r = MAX_W'(step) & ones;
      default: begin
        if (s < w)
          r = MAX_W'(1) << (w - 1 - s);
        else
          r = MAX_W'(1) << (s - w + 1);
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_btn_debounce.sv
// Button synchronizer, debounce filter and press pulse.
// Pulse fires once when a stable release->press level is accepted.
module btn_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES);

  logic          s1;
  logic          s2;
  logic          level;
  logic [CW-1:0] cnt;

  // synchronize, then accept a level after DB_CYCLES equal samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= btn_n;
      s2    <= s1;
      press <= 1'b0;
      if (s2 != level) begin
        if (cnt == CW'(DB_CYCLES - 1)) begin
          level <= s2;
          cnt   <= '0;
          press <= ~s2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED chaser: step divider, mode/pause control, registered LEDs.
// Mode press overrides a coincident step advance.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int LED_W     = 8,
  parameter int NUM_MODES = 4,
  parameter int TICK_DIV  = 6_250_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic             Clk_50MHz,
  input  logic             Rst_OnBoard,
  input  logic             Btn_Mode_n,
  input  logic             Btn_Pause_n,
  input  logic [1:0]       Speed_Sel,
  output logic [LED_W-1:0] LED_Output,
  output logic [1:0]       Mode_Index,
  output logic             Step_Tick
);

  localparam int DW = $clog2(TICK_DIV);

  logic              mode_press;
  logic              pause_press;
  logic [1:0]        mode_q;
  logic [1:0]        next_mode;
  logic [STEP_W-1:0] step_q;
  logic [DW-1:0]     div_q;
  logic [DW-1:0]     period_m1;
  logic [1:0]        speed_q;
  logic              pause_q;
  logic              tick_q;
  logic              wrap;
  logic              last_step;
  logic [LED_W-1:0]  led_q;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk   (Clk_50MHz),
    .rst_n (Rst_OnBoard),
    .btn_n (Btn_Mode_n),
    .press (mode_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
    .clk   (Clk_50MHz),
    .rst_n (Rst_OnBoard),
    .btn_n (Btn_Pause_n),
    .press (pause_press)
  );

  // period end, step end and next mode decode
  always_comb begin
    period_m1 = DW'((TICK_DIV >> speed_q) - 1);
    wrap      = (div_q == period_m1);
    last_step = (step_q == step_len(mode_q, LED_W) - STEP_W'(1));
    next_mode = (mode_q == 2'(NUM_MODES - 1))
              ? 2'd0 : mode_q + 2'd1;
  end

  // divider, step and mode; speed latched only at period end
  always_ff @(posedge Clk_50MHz or negedge Rst_OnBoard) begin
    if (!Rst_OnBoard) begin
      mode_q  <= MODE_WALK;
      step_q  <= '0;
      div_q   <= '0;
      speed_q <= 2'd0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (mode_press) begin
        mode_q <= next_mode;
        step_q <= '0;
        div_q  <= '0;
      end else if (!pause_q) begin
        if (wrap) begin
          div_q   <= '0;
          speed_q <= Speed_Sel;
          tick_q  <= 1'b1;
          step_q  <= last_step ? '0 : step_q + 1'b1;
        end else begin
          div_q <= div_q + 1'b1;
        end
      end
    end
  end

  // pause flag toggles on each accepted press
  always_ff @(posedge Clk_50MHz or negedge Rst_OnBoard) begin
    if (!Rst_OnBoard)
      pause_q <= 1'b0;
    else if (pause_press)
      pause_q <= ~pause_q;
  end

  // LED register follows mode/step one cycle later
  always_ff @(posedge Clk_50MHz or negedge Rst_OnBoard) begin
    if (!Rst_OnBoard)
      led_q <= {1'b1, {(LED_W-1){1'b0}}};
    else
      led_q <= LED_W'(pattern(mode_q, step_q, LED_W));
  end

  assign LED_Output = led_q;
  assign Mode_Index = mode_q;
  assign Step_Tick  = tick_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer.
// W=8, TICK_DIV=8, DB_CYCLES=4; checks sampled on falling edges.
module tb_led_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_mode = 1'b1;
  logic       btn_pause = 1'b1;
  logic [1:0] speed = 2'd0;
  logic [7:0] led;
  logic [1:0] mode;
  logic       tick;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_tick = 0;
  int prev_tick = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  led_pattern_sequencer #(
    .LED_W     (8),
    .NUM_MODES (4),
    .TICK_DIV  (8),
    .DB_CYCLES (4)
  ) dut (
    .Clk_50MHz   (clk),
    .Rst_OnBoard (rst_n),
    .Btn_Mode_n  (btn_mode),
    .Btn_Pause_n (btn_pause),
    .Speed_Sel   (speed),
    .LED_Output  (led),
    .Mode_Index  (mode),
    .Step_Tick   (tick)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 200);
    prev_tick = last_tick;
    last_tick = cyc;
    check("tick_seen", 32'(tick), 32'd1);
  endtask

  task automatic step_led(input string tag,
                          input logic [7:0] exp);
    wait_tick();
    @(negedge clk);
    check(tag, 32'(led), 32'(exp));
  endtask

  task automatic press(input bit pause_btn, input int n);
    if (pause_btn) btn_pause = 1'b0;
    else btn_mode = 1'b0;
    repeat (n) @(negedge clk);
    btn_pause = 1'b1;
    btn_mode  = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] seq0 [13] = '{8'h40, 8'h20, 8'h10, 8'h08,
                            8'h04, 8'h02, 8'h01, 8'h00,
                            8'hFF, 8'h00, 8'hFF, 8'h00,
                            8'h80};
  logic [7:0] seq1 [15] = '{8'h42, 8'h24, 8'h18, 8'h18,
                            8'h24, 8'h42, 8'h81, 8'h00,
                            8'hFF, 8'h00, 8'hFF, 8'h00,
                            8'hFF, 8'h00, 8'h81};

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nt;
    int seen;
    int rel;
    #2 rst_n = 1'b0;
    idle(3);
    check("rst_led", 32'(led), 32'h80);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    rst_n = 1'b1;

    // mode 0 walk + flash
    for (int i = 0; i < 13; i++) begin
      step_led("walk_led", seq0[i]);
      if (i > 0)
        check("walk_period", 32'(last_tick - prev_tick), 32'd8);
    end

    // mode 1 converge/diverge
    press(1'b0, 10);
    check("m1_mode", 32'(mode), 32'd1);
    check("m1_led0", 32'(led), 32'h81);
    for (int i = 0; i < 15; i++)
      step_led("mirror_led", seq1[i]);

    // glitchy press gives exactly one advance
    btn_mode = 1'b0;
    idle(2);
    btn_mode = 1'b1;
    idle(2);
    btn_mode = 1'b0;
    idle(10);
    btn_mode = 1'b1;
    check("glitch_mode", 32'(mode), 32'd2);
    idle(30);
    check("release_mode", 32'(mode), 32'd2);

    // mode 3 ping-pong, pause at step 5
    press(1'b0, 10);
    check("m3_mode", 32'(mode), 32'd3);
    check("m3_led0", 32'(led), 32'h80);
    step_led("pp_led1", 8'h40);
    step_led("pp_led2", 8'h20);
    step_led("pp_led3", 8'h10);
    step_led("pp_led4", 8'h08);
    idle(3);
    press(1'b1, 10);
    check("pause_led0", 32'(led), 32'h04);
    nt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tick) nt++;
    end
    check("pause_ticks", 32'(nt), 32'd0);
    check("pause_led", 32'(led), 32'h04);
    press(1'b1, 10);
    step_led("resume_led", 8'h02);

    // speed change mid-period
    speed = 2'd2;
    step_led("spd_led7", 8'h01);
    check("spd_period8", 32'(last_tick - prev_tick), 32'd8);
    step_led("spd_led8", 8'h02);
    check("spd_period2a", 32'(last_tick - prev_tick), 32'd2);
    step_led("spd_led9", 8'h04);
    check("spd_period2b", 32'(last_tick - prev_tick), 32'd2);

    // mode press landing on a divider wrap
    btn_mode = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (seen == 1) begin
        check("coinc_led", 32'(led), 32'h80);
        seen = 2;
      end
      if (seen == 0 && mode != 2'd3) begin
        check("coinc_tick", 32'(tick), 32'd0);
        check("coinc_mode", 32'(mode), 32'd0);
        seen = 1;
      end
    end
    btn_mode = 1'b1;
    check("coinc_seen", 32'(seen), 32'd2);

    // async reset while paused in mode 2
    speed = 2'd0;
    idle(12);
    press(1'b0, 10);
    idle(12);
    press(1'b0, 10);
    idle(12);
    check("pre_rst_mode", 32'(mode), 32'd2);
    press(1'b1, 10);
    idle(12);
    nt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tick) nt++;
    end
    check("pre_rst_paused", 32'(nt), 32'd0);
    #3 rst_n = 1'b0;
    #1;
    check("arst_mode", 32'(mode), 32'd0);
    check("arst_led", 32'(led), 32'h80);
    check("arst_tick", 32'(tick), 32'd0);
    idle(2);
    rst_n = 1'b1;
    rel = cyc;
    step_led("post_rst_led", 8'h40);
    check("post_rst_period", 32'(last_tick - rel), 32'd8);

    // four presses cycle back to mode 0
    for (int i = 1; i <= 4; i++) begin
      press(1'b0, 10);
      idle(12);
      check("cycle_mode", 32'(mode), 32'(i % 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
